// File: rtl/slice_header_field_sequencer_pkg.sv
// ============================================================================
// Module      : slice_header_field_sequencer_pkg
// Description : State codes, field widths and next-field decode for the
//               slice-header sequencer. SLICE_HDR_ERR_CHK_EN adds the error state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slice_header_field_sequencer_pkg;

    localparam int unsigned STATE_W        = 5;
    localparam logic [4:0]  NAL_IDR        = 5'd5;
    localparam int unsigned FIRST_MB_W     = 8;
    localparam int unsigned SLICE_TYPE_W   = 4;
    localparam int unsigned PPS_ID_W       = 8;
    localparam int unsigned FRAME_NUM_W    = 10;
    localparam int unsigned IDR_PIC_ID_W   = 8;
    localparam int unsigned POC_LSB_W      = 10;
    localparam int unsigned QP_DELTA_W     = 6;
    localparam int unsigned DBF_IDC_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 5'd0,
        ST_FIRST_MB   = 5'd1,
        ST_SLICE_TYPE = 5'd2,
        ST_PPS_ID     = 5'd3,
        ST_FRAME_NUM  = 5'd4,
        ST_IDR_PIC_ID = 5'd5,
        ST_POC_LSB    = 5'd6,
        ST_QP_DELTA   = 5'd7,
        ST_DBF_IDC    = 5'd8,
`ifdef SLICE_HDR_ERR_CHK_EN
        ST_END        = 5'd9,
        ST_ERR        = 5'd10
`else
        ST_END        = 5'd9
`endif
    } state_t;

    // Optional fields are chained past in the same decode, so a skip costs no cycle.
    function automatic state_t next_field(input state_t     cur,
                                          input logic [4:0] nal_unit_type,
                                          input logic [1:0] poc_type,
                                          input logic       dbf_present);
        state_t nxt;
        nxt = ST_END;
        case (cur)
            ST_FIRST_MB:   nxt = ST_SLICE_TYPE;
            ST_SLICE_TYPE: nxt = ST_PPS_ID;
            ST_PPS_ID:     nxt = ST_FRAME_NUM;
            ST_FRAME_NUM: begin
                if (nal_unit_type == NAL_IDR) nxt = ST_IDR_PIC_ID;
                else if (poc_type == 2'd0)    nxt = ST_POC_LSB;
                else                          nxt = ST_QP_DELTA;
            end
            ST_IDR_PIC_ID: nxt = (poc_type == 2'd0) ? ST_POC_LSB : ST_QP_DELTA;
            ST_POC_LSB:    nxt = ST_QP_DELTA;
            ST_QP_DELTA:   nxt = dbf_present ? ST_DBF_IDC : ST_END;
            default:       nxt = ST_END;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slice_header_field_sequencer_se_code_map.sv
// ============================================================================
// Module      : se_code_map
// Description : Signed Exp-Golomb mapping, codeNum to 6-bit two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module se_code_map
    import slice_header_field_sequencer_pkg::*;
(
    input  logic [7:0]            code_num,
    output logic [QP_DELTA_W-1:0] se_value
);

    logic [7:0] w_mag;
    logic [7:0] w_sel;

    // Odd k -> +(k+1)/2, even k -> -k/2; upper bits dropped by truncation.
    assign w_mag    = {1'b0, code_num[7:1]} + {7'd0, code_num[0]};
    assign w_sel    = code_num[0] ? w_mag : (8'd0 - w_mag);
    assign se_value = w_sel[QP_DELTA_W-1:0];

    logic w_unused_hi;
    assign w_unused_hi = ^w_sel[7:QP_DELTA_W];

endmodule

`default_nettype wire

// File: rtl/slice_header_field_sequencer.sv
// ============================================================================
// Module      : slice_header_field_sequencer
// Description : Steps the slice-header syntax elements, drives consume length,
//               registers parsed fields. Optional macro: SLICE_HDR_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_header_field_sequencer
    import slice_header_field_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    slice_header_start,
    input  logic [4:0]              nal_unit_type,
    input  logic [1:0]              pic_order_cnt_type,
    input  logic                    deblocking_filter_control_present_flag,
    input  logic                    BitStream_buffer_valid,
    input  logic [4:0]              exp_golomb_len,
    input  logic [7:0]              exp_golomb_decoding_output,
    input  logic [3:0]              dependent_variable_len,
    input  logic [9:0]              dependent_variable_decoding_output,
    output logic [STATE_W-1:0]      slice_header_state,
    output logic [4:0]              bits_consume,
    output logic                    bits_consume_valid,
    output logic [FIRST_MB_W-1:0]   first_mb_in_slice,
    output logic [SLICE_TYPE_W-1:0] slice_type,
    output logic [PPS_ID_W-1:0]     pic_parameter_set_id,
    output logic [FRAME_NUM_W-1:0]  frame_num,
    output logic [IDR_PIC_ID_W-1:0] idr_pic_id,
    output logic [POC_LSB_W-1:0]    pic_order_cnt_lsb,
    output logic [QP_DELTA_W-1:0]   slice_qp_delta,
    output logic [DBF_IDC_W-1:0]    disable_deblocking_filter_idc,
    output logic                    slice_header_done,
    output logic                    slice_header_err
);

    state_t                r_state;
    state_t                w_next;
    logic                  w_field_state;
    logic                  w_dep_state;
    logic                  w_err;
    logic [QP_DELTA_W-1:0] w_se;

    se_code_map u_se_code_map (
        .code_num (exp_golomb_decoding_output),
        .se_value (w_se)
    );

    assign slice_header_state = r_state;

    always_comb begin
        w_field_state = 1'b0;
        w_dep_state   = 1'b0;
        case (r_state)
            ST_FIRST_MB, ST_SLICE_TYPE, ST_PPS_ID, ST_IDR_PIC_ID,
            ST_QP_DELTA, ST_DBF_IDC:          w_field_state = 1'b1;
            ST_FRAME_NUM, ST_POC_LSB: begin
                w_field_state = 1'b1;
                w_dep_state   = 1'b1;
            end
            default: begin
                w_field_state = 1'b0;
                w_dep_state   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bits_consume_valid = w_field_state & BitStream_buffer_valid;
        bits_consume       = 5'd0;
        if (bits_consume_valid)
            bits_consume = w_dep_state ? {1'b0, dependent_variable_len} : exp_golomb_len;
    end

    always_comb begin
        w_next = next_field(r_state, nal_unit_type, pic_order_cnt_type,
                            deblocking_filter_control_present_flag);
    end

`ifdef SLICE_HDR_ERR_CHK_EN
    always_comb begin
        w_err = 1'b0;
        if (w_field_state && !w_dep_state && exp_golomb_len > 5'd15)
            w_err = 1'b1;
        case (r_state)
            ST_SLICE_TYPE: if (exp_golomb_decoding_output > 8'd9)  w_err = 1'b1;
            ST_DBF_IDC:    if (exp_golomb_decoding_output > 8'd2)  w_err = 1'b1;
            ST_QP_DELTA:   if (exp_golomb_decoding_output > 8'd52) w_err = 1'b1;
            default: ;
        endcase
    end
`else
    assign w_err            = 1'b0;
    assign slice_header_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                       <= ST_IDLE;
            first_mb_in_slice             <= '0;
            slice_type                    <= '0;
            pic_parameter_set_id          <= '0;
            frame_num                     <= '0;
            idr_pic_id                    <= '0;
            pic_order_cnt_lsb             <= '0;
            slice_qp_delta                <= '0;
            disable_deblocking_filter_idc <= '0;
            slice_header_done             <= 1'b0;
`ifdef SLICE_HDR_ERR_CHK_EN
            slice_header_err              <= 1'b0;
`endif
        end else begin
            slice_header_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (slice_header_start) begin
                        r_state                       <= ST_FIRST_MB;
                        idr_pic_id                    <= '0;
                        pic_order_cnt_lsb             <= '0;
                        disable_deblocking_filter_idc <= '0;
`ifdef SLICE_HDR_ERR_CHK_EN
                        slice_header_err              <= 1'b0;
`endif
                    end
                end
                ST_END: r_state <= ST_IDLE;
`ifdef SLICE_HDR_ERR_CHK_EN
                ST_ERR: r_state <= ST_IDLE;
`endif
                default: begin
                    if (BitStream_buffer_valid) begin
                        case (r_state)
                            ST_FIRST_MB:   first_mb_in_slice    <= exp_golomb_decoding_output;
                            ST_SLICE_TYPE: slice_type           <= exp_golomb_decoding_output[SLICE_TYPE_W-1:0];
                            ST_PPS_ID:     pic_parameter_set_id <= exp_golomb_decoding_output;
                            ST_FRAME_NUM:  frame_num            <= dependent_variable_decoding_output;
                            ST_IDR_PIC_ID: idr_pic_id           <= exp_golomb_decoding_output;
                            ST_POC_LSB:    pic_order_cnt_lsb    <= dependent_variable_decoding_output;
                            ST_QP_DELTA:   slice_qp_delta       <= w_se;
                            ST_DBF_IDC:    disable_deblocking_filter_idc <=
                                               exp_golomb_decoding_output[DBF_IDC_W-1:0];
                            default: ;
                        endcase
`ifdef SLICE_HDR_ERR_CHK_EN
                        if (w_err) begin
                            r_state          <= ST_ERR;
                            slice_header_err <= 1'b1;
                        end else
`endif
                        begin
                            r_state           <= w_next;
                            slice_header_done <= (w_next == ST_END) && !w_err;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slice_header_field_sequencer.sv
// ============================================================================
// Module      : tb_slice_header_field_sequencer
// Description : Directed self-checking bench for slice_header_field_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slice_header_field_sequencer;

    localparam logic [4:0] S_IDLE = 5'd0, S_FMB = 5'd1, S_STYPE = 5'd2, S_PPS = 5'd3,
                           S_FRAME = 5'd4, S_IDR = 5'd5, S_POC = 5'd6, S_QP = 5'd7,
                           S_DBF = 5'd8, S_END = 5'd9, S_ERR = 5'd10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slice_header_start = 1'b0;
    logic [4:0]  nal_unit_type = 5'd1;
    logic [1:0]  pic_order_cnt_type = 2'd0;
    logic        deblocking_filter_control_present_flag = 1'b0;
    logic        BitStream_buffer_valid = 1'b0;
    logic [4:0]  exp_golomb_len = 5'd0;
    logic [7:0]  exp_golomb_decoding_output = 8'd0;
    logic [3:0]  dependent_variable_len = 4'd0;
    logic [9:0]  dependent_variable_decoding_output = 10'd0;
    logic [4:0]  slice_header_state;
    logic [4:0]  bits_consume;
    logic        bits_consume_valid;
    logic [7:0]  first_mb_in_slice;
    logic [3:0]  slice_type;
    logic [7:0]  pic_parameter_set_id;
    logic [9:0]  frame_num;
    logic [7:0]  idr_pic_id;
    logic [9:0]  pic_order_cnt_lsb;
    logic [5:0]  slice_qp_delta;
    logic [1:0]  disable_deblocking_filter_idc;
    logic        slice_header_done;
    logic        slice_header_err;

    int errors = 0;
    int checks = 0;
    int consumed_sum = 0;
    time t_start;

    slice_header_field_sequencer dut (
        .clk                                    (clk),
        .reset                                  (reset),
        .slice_header_start                     (slice_header_start),
        .nal_unit_type                          (nal_unit_type),
        .pic_order_cnt_type                     (pic_order_cnt_type),
        .deblocking_filter_control_present_flag (deblocking_filter_control_present_flag),
        .BitStream_buffer_valid                 (BitStream_buffer_valid),
        .exp_golomb_len                         (exp_golomb_len),
        .exp_golomb_decoding_output             (exp_golomb_decoding_output),
        .dependent_variable_len                 (dependent_variable_len),
        .dependent_variable_decoding_output     (dependent_variable_decoding_output),
        .slice_header_state                     (slice_header_state),
        .bits_consume                           (bits_consume),
        .bits_consume_valid                     (bits_consume_valid),
        .first_mb_in_slice                      (first_mb_in_slice),
        .slice_type                             (slice_type),
        .pic_parameter_set_id                   (pic_parameter_set_id),
        .frame_num                              (frame_num),
        .idr_pic_id                             (idr_pic_id),
        .pic_order_cnt_lsb                      (pic_order_cnt_lsb),
        .slice_qp_delta                         (slice_qp_delta),
        .disable_deblocking_filter_idc          (disable_deblocking_filter_idc),
        .slice_header_done                      (slice_header_done),
        .slice_header_err                       (slice_header_err)
    );

    always #5 clk = ~clk;

    // Entered and left on a falling edge; presents one field and checks the consume outputs.
    task automatic drive_field(input logic [4:0] exp_state, input logic v,
                               input logic [4:0] eg_len, input logic [7:0] eg_out,
                               input logic [3:0] dl, input logic [9:0] dout,
                               input logic [4:0] exp_cons);
        BitStream_buffer_valid             = v;
        exp_golomb_len                     = eg_len;
        exp_golomb_decoding_output         = eg_out;
        dependent_variable_len             = dl;
        dependent_variable_decoding_output = dout;
        #1;
        checks++;
        if (slice_header_state !== exp_state) begin
            errors++;
            $display("FAIL field_state: got %0d expected %0d", slice_header_state, exp_state);
        end
        checks++;
        if (bits_consume_valid !== v || bits_consume !== (v ? exp_cons : 5'd0)) begin
            errors++;
            $display("FAIL consume(state %0d): got valid=%0b len=%0d expected valid=%0b len=%0d",
                     exp_state, bits_consume_valid, bits_consume, v, v ? exp_cons : 5'd0);
        end
        if (bits_consume_valid === 1'b1) consumed_sum += int'(bits_consume);
        @(negedge clk);
    endtask

    task automatic do_start();
        slice_header_start = 1'b1;
        t_start = $time;
        @(negedge clk);
        slice_header_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (slice_header_state !== S_IDLE || bits_consume_valid !== 1'b0 || bits_consume !== 5'd0 ||
            slice_header_done !== 1'b0 || slice_header_err !== 1'b0 || first_mb_in_slice !== 8'd0 ||
            frame_num !== 10'd0 || slice_qp_delta !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d cv=%0b done=%0b err=%0b fmb=%0d fn=%0d qp=%0d expected all 0",
                     slice_header_state, bits_consume_valid, slice_header_done, slice_header_err,
                     first_mb_in_slice, frame_num, slice_qp_delta);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Non-IDR, poc type 0, no deblocking control, window always valid.
    task automatic test_non_idr();
        nal_unit_type = 5'd1; pic_order_cnt_type = 2'd0;
        deblocking_filter_control_present_flag = 1'b0;
        do_start();
        drive_field(S_FMB,   1'b1, 5'd5, 8'd3, 4'd9, 10'h3FF, 5'd5);
        drive_field(S_STYPE, 1'b1, 5'd1, 8'd0, 4'd9, 10'h3FF, 5'd1);
        drive_field(S_PPS,   1'b1, 5'd1, 8'd0, 4'd9, 10'h3FF, 5'd1);
        drive_field(S_FRAME, 1'b1, 5'd9, 8'd77, 4'd4, 10'h00A, 5'd4);
        drive_field(S_POC,   1'b1, 5'd9, 8'd77, 4'd4, 10'h005, 5'd4);
        drive_field(S_QP,    1'b1, 5'd3, 8'd3, 4'd9, 10'h3FF, 5'd3);
        BitStream_buffer_valid = 1'b0;
        #1;
        checks++;
        if (slice_header_state !== S_END || slice_header_done !== 1'b1 || ($time - t_start) != 71) begin
            errors++;
            $display("FAIL done_timing: got state=%0d done=%0b dt=%0t expected state=9 done=1 dt=71",
                     slice_header_state, slice_header_done, $time - t_start);
        end
        @(negedge clk);
        #1;
        checks++;
        if (slice_header_state !== S_IDLE || slice_header_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got state=%0d done=%0b expected state=0 done=0",
                     slice_header_state, slice_header_done);
        end
        checks++;
        if (first_mb_in_slice !== 8'd3 || slice_type !== 4'd0 || pic_parameter_set_id !== 8'd0 ||
            frame_num !== 10'd10 || pic_order_cnt_lsb !== 10'd5 || slice_qp_delta !== 6'd2 ||
            idr_pic_id !== 8'd0 || disable_deblocking_filter_idc !== 2'd0) begin
            errors++;
            $display("FAIL non_idr_fields: got fmb=%0d st=%0d pps=%0d fn=%0d poc=%0d qp=%0d idr=%0d dbf=%0d expected 3 0 0 10 5 2 0 0",
                     first_mb_in_slice, slice_type, pic_parameter_set_id, frame_num,
                     pic_order_cnt_lsb, slice_qp_delta, idr_pic_id, disable_deblocking_filter_idc);
        end
        @(negedge clk);
    endtask

    // IDR with poc type 2: idr_pic_id visited, poc_lsb skipped, qp codeNum 52 -> -26.
    task automatic test_idr_skip();
        nal_unit_type = 5'd5; pic_order_cnt_type = 2'd2;
        deblocking_filter_control_present_flag = 1'b1;
        consumed_sum = 0;
        do_start();
        drive_field(S_FMB,   1'b1, 5'd1,  8'd0,  4'd9, 10'h3FF, 5'd1);
        drive_field(S_STYPE, 1'b1, 5'd7,  8'd7,  4'd9, 10'h3FF, 5'd7);
        drive_field(S_PPS,   1'b1, 5'd3,  8'd1,  4'd9, 10'h3FF, 5'd3);
        drive_field(S_FRAME, 1'b1, 5'd13, 8'd99, 4'd4, 10'h003, 5'd4);
        drive_field(S_IDR,   1'b1, 5'd3,  8'd1,  4'd9, 10'h3FF, 5'd3);
        drive_field(S_QP,    1'b1, 5'd11, 8'd52, 4'd9, 10'h3FF, 5'd11);
        drive_field(S_DBF,   1'b1, 5'd3,  8'd1,  4'd9, 10'h3FF, 5'd3);
        BitStream_buffer_valid = 1'b0;
        #1;
        checks++;
        if (slice_header_state !== S_END || slice_header_done !== 1'b1) begin
            errors++;
            $display("FAIL idr_end: got state=%0d done=%0b expected state=9 done=1",
                     slice_header_state, slice_header_done);
        end
        checks++;
        if (consumed_sum != 32) begin
            errors++;
            $display("FAIL idr_consume_sum: got %0d expected 32", consumed_sum);
        end
        checks++;
        if (slice_type !== 4'd7 || pic_parameter_set_id !== 8'd1 || frame_num !== 10'd3 ||
            idr_pic_id !== 8'd1 || pic_order_cnt_lsb !== 10'd0 || slice_qp_delta !== 6'b100110 ||
            disable_deblocking_filter_idc !== 2'd1) begin
            errors++;
            $display("FAIL idr_fields: got st=%0d pps=%0d fn=%0d idr=%0d poc=%0d qp=%b dbf=%0d expected 7 1 3 1 0 100110 1",
                     slice_type, pic_parameter_set_id, frame_num, idr_pic_id,
                     pic_order_cnt_lsb, slice_qp_delta, disable_deblocking_filter_idc);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Window invalid for three cycles in frame_num_s; idr cleared by start.
    task automatic test_stall();
        nal_unit_type = 5'd1; pic_order_cnt_type = 2'd1;
        deblocking_filter_control_present_flag = 1'b0;
        do_start();
        checks++;
        if (idr_pic_id !== 8'd0 || disable_deblocking_filter_idc !== 2'd0) begin
            errors++;
            $display("FAIL start_clear: got idr=%0d dbf=%0d expected 0 0",
                     idr_pic_id, disable_deblocking_filter_idc);
        end
        drive_field(S_FMB,   1'b1, 5'd3, 8'd2, 4'd9, 10'h3FF, 5'd3);
        drive_field(S_STYPE, 1'b1, 5'd3, 8'd1, 4'd9, 10'h3FF, 5'd3);
        drive_field(S_PPS,   1'b1, 5'd1, 8'd0, 4'd9, 10'h3FF, 5'd1);
        for (int i = 0; i < 3; i++) begin
            drive_field(S_FRAME, 1'b0, 5'd9, 8'd5, 4'd10, 10'h2FF, 5'd0);
            checks++;
            if (frame_num !== 10'd3) begin
                errors++;
                $display("FAIL stall_hold: got frame_num=%0d expected 3", frame_num);
            end
        end
        drive_field(S_FRAME, 1'b1, 5'd9, 8'd5, 4'd10, 10'h2FF, 5'd10);
        checks++;
        if (frame_num !== 10'h2FF) begin
            errors++;
            $display("FAIL stall_latch: got frame_num=%0h expected 2ff", frame_num);
        end
        drive_field(S_QP, 1'b1, 5'd1, 8'd0, 4'd9, 10'h3FF, 5'd1);
        BitStream_buffer_valid = 1'b0;
        #1;
        checks++;
        if (slice_header_state !== S_END || slice_qp_delta !== 6'd0 || idr_pic_id !== 8'd0) begin
            errors++;
            $display("FAIL stall_end: got state=%0d qp=%0d idr=%0d expected 9 0 0",
                     slice_header_state, slice_qp_delta, idr_pic_id);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Reset asserted in frame_num_s, then a clean parse.
    task automatic test_reset_mid_header();
        nal_unit_type = 5'd1; pic_order_cnt_type = 2'd0;
        deblocking_filter_control_present_flag = 1'b0;
        do_start();
        drive_field(S_FMB,   1'b1, 5'd5, 8'd9, 4'd9, 10'h3FF, 5'd5);
        drive_field(S_STYPE, 1'b1, 5'd3, 8'd2, 4'd9, 10'h3FF, 5'd3);
        drive_field(S_PPS,   1'b1, 5'd1, 8'd0, 4'd9, 10'h3FF, 5'd1);
        BitStream_buffer_valid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (slice_header_state !== S_IDLE || bits_consume_valid !== 1'b0 || bits_consume !== 5'd0 ||
            first_mb_in_slice !== 8'd0 || slice_type !== 4'd0 || frame_num !== 10'd0 ||
            slice_qp_delta !== 6'd0 || slice_header_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got state=%0d cv=%0b bc=%0d fmb=%0d st=%0d fn=%0d qp=%0d done=%0b expected all 0",
                     slice_header_state, bits_consume_valid, bits_consume, first_mb_in_slice,
                     slice_type, frame_num, slice_qp_delta, slice_header_done);
        end
        @(negedge clk);
        reset = 1'b0;
        BitStream_buffer_valid = 1'b0;
        @(negedge clk);
        test_non_idr();
    endtask

`ifdef SLICE_HDR_ERR_CHK_EN
    task automatic test_err_check();
        nal_unit_type = 5'd1; pic_order_cnt_type = 2'd0;
        do_start();
        drive_field(S_FMB,   1'b1, 5'd1, 8'd0,  4'd9, 10'h3FF, 5'd1);
        drive_field(S_STYPE, 1'b1, 5'd7, 8'd12, 4'd9, 10'h3FF, 5'd7);
        BitStream_buffer_valid = 1'b0;
        #1;
        checks++;
        if (slice_header_state !== S_ERR || slice_header_err !== 1'b1 || slice_header_done !== 1'b0) begin
            errors++;
            $display("FAIL err_entry: got state=%0d err=%0b done=%0b expected 10 1 0",
                     slice_header_state, slice_header_err, slice_header_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (slice_header_state !== S_IDLE || slice_header_err !== 1'b1 || slice_header_done !== 1'b0) begin
            errors++;
            $display("FAIL err_exit: got state=%0d err=%0b done=%0b expected 0 1 0",
                     slice_header_state, slice_header_err, slice_header_done);
        end
        @(negedge clk);
        do_start();
        #1;
        checks++;
        if (slice_header_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %0b expected 0", slice_header_err);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_non_idr();
        test_idr_skip();
        test_stall();
        test_reset_mid_header();
`ifdef SLICE_HDR_ERR_CHK_EN
        test_err_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
